// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around the shared memory port arbiter.
// The arbiter takes the master view; requesters and the memory model take the slave view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_ack;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic                  stall_if;
  logic                  stall_mem;

  modport master (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ack,
    output dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  modport slave (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ack,
    input  dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and MEM-stage loads/stores.
// Data wins ties; a saturating starvation counter forces a fetch grant after STARVE_LIM data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.master io_bus
);

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyDm,
    StBusyDrop
  } state_e;

  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  state_e                r_state;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;
  logic                  r_if_ack;
  logic                  r_dm_ack;
  logic [3:0]            r_starve;

  logic w_elig_if;
  logic w_elig_dm;
  logic w_grant_if;
  logic w_grant_dm;

  // A requester is ignored in the cycle its own ack is high, so it cannot be re-granted early.
  assign w_elig_if  = io_bus.if_req & ~io_bus.if_flush & ~r_if_ack;
  assign w_elig_dm  = io_bus.dm_req & ~r_dm_ack;
  assign w_grant_if = w_elig_if & (~w_elig_dm | (r_starve == StarveLim));
  assign w_grant_dm = w_elig_dm & ~w_grant_if;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_starve    <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!io_bus.if_req) begin
            r_starve <= '0;
          end
          if (w_grant_if) begin
            r_state    <= StBusyIf;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= io_bus.if_addr;
            r_starve   <= '0;
          end else if (w_grant_dm) begin
            r_state     <= StBusyDm;
            r_mem_req   <= 1'b1;
            r_mem_we    <= io_bus.dm_we;
            r_mem_addr  <= io_bus.dm_addr;
            r_mem_wdata <= io_bus.dm_wdata;
            if (io_bus.if_req && (r_starve != StarveLim)) begin
              r_starve <= r_starve + 4'd1;
            end
          end
        end
        StBusyIf: begin
          // A flush coinciding with the response still drops the fetched word.
          if (io_bus.mem_ack) begin
            r_state   <= StIdle;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (!io_bus.if_flush) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= io_bus.mem_rdata;
            end
          end else if (io_bus.if_flush) begin
            r_state <= StBusyDrop;
          end
        end
        StBusyDm: begin
          if (io_bus.mem_ack) begin
            r_state   <= StIdle;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_dm_ack  <= 1'b1;
            if (!r_mem_we) begin
              r_dm_rdata <= io_bus.mem_rdata;
            end
          end
        end
        StBusyDrop: begin
          if (io_bus.mem_ack) begin
            r_state   <= StIdle;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.if_rdata  = r_if_rdata;
  assign io_bus.if_ack    = r_if_ack;
  assign io_bus.dm_rdata  = r_dm_rdata;
  assign io_bus.dm_ack    = r_dm_ack;
  assign io_bus.stall_if  = io_bus.if_req & ~r_if_ack;
  assign io_bus.stall_mem = io_bus.dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level ownership model checked every cycle.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STARVE_LIM(LIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks after mem_wait extra cycles; force_ack injects a stray response.
  logic [31:0] mem [logic [31:0]];
  int          mem_wait;
  int          rsp_cnt;
  bit          force_ack;
  logic [31:0] force_data;

  task automatic step();
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    if (force_ack) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = force_data;
      force_ack     = 1'b0;
    end else if (bus.mem_req === 1'b1) begin
      if (rsp_cnt == mem_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        rsp_cnt = 0;
      end else begin
        rsp_cnt++;
      end
    end else begin
      rsp_cnt = 0;
    end
  endtask

  // Model: who owns the memory (0 nobody, 1 fetch, 2 data, 3 cancelled fetch) and what it latched.
  int          m_owner;
  logic        m_req, m_we, m_if_ack, m_dm_ack;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  int          m_starve;
  bit          cmp_en;

  task automatic model_step();
    bit fetch_ok, data_ok, nx_if_ack, nx_dm_ack;
    if (!rst_n) begin
      m_owner = 0; m_req = 0; m_we = 0; m_if_ack = 0; m_dm_ack = 0;
      m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0; m_starve = 0;
      return;
    end
    fetch_ok  = bus.if_req && !bus.if_flush && !m_if_ack;
    data_ok   = bus.dm_req && !m_dm_ack;
    nx_if_ack = 0;
    nx_dm_ack = 0;
    if (m_owner == 0) begin
      if (!bus.if_req) m_starve = 0;
      if (fetch_ok && (!data_ok || m_starve == LIM)) begin
        m_owner = 1; m_req = 1; m_we = 0; m_addr = bus.if_addr; m_starve = 0;
      end else if (data_ok) begin
        m_owner = 2; m_req = 1; m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
        if (bus.if_req) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
      end
    end else if (bus.mem_ack) begin
      if (m_owner == 1 && !bus.if_flush) begin
        nx_if_ack  = 1;
        m_if_rdata = bus.mem_rdata;
      end
      if (m_owner == 2) begin
        nx_dm_ack = 1;
        if (!m_we) m_dm_rdata = bus.mem_rdata;
      end
      m_owner = 0; m_req = 0; m_we = 0;
    end else if (m_owner == 1 && bus.if_flush) begin
      m_owner = 3;
    end
    m_if_ack = nx_if_ack;
    m_dm_ack = nx_dm_ack;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("mem_req",   bus.mem_req,   m_req);
      check("mem_we",    bus.mem_we,    m_we);
      check("mem_addr",  bus.mem_addr,  m_addr);
      check("mem_wdata", bus.mem_wdata, m_wdata);
      check("if_ack",    bus.if_ack,    m_if_ack);
      check("dm_ack",    bus.dm_ack,    m_dm_ack);
      check("if_rdata",  bus.if_rdata,  m_if_rdata);
      check("dm_rdata",  bus.dm_rdata,  m_dm_rdata);
      check("stall_if",  bus.stall_if,  bus.if_req & ~m_if_ack);
      check("stall_mem", bus.stall_mem, bus.dm_req & ~m_dm_ack);
    end
  end

  task automatic dm_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd);
    bit done;
    bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wd;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (bus.dm_ack === 1'b1) done = 1;
    end
    check("dm_access_done", done, 1'b1);
    rd = bus.dm_rdata;
    bus.dm_req = 1'b0;
  endtask

  task automatic wait_if_ack(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (bus.if_ack === 1'b1) done = 1;
    end
    check(name, done, 1'b1);
  endtask

  int          grants[$];
  int          exp_seq[10];
  logic        prev_req;
  logic [31:0] rd;

  initial begin
    n_cmp = 0; n_err = 0; cmp_en = 0;
    rst_n = 1'b0;
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    mem_wait = 0; rsp_cnt = 0; force_ack = 0; force_data = 0;
    mem[32'h40]  = 32'hDEADBEEF;
    mem[32'h100] = 32'h00000093;
    mem[32'h200] = 32'h00000013;
    mem[32'h20]  = 32'h11112222;
    mem[32'h300] = 32'hCAFEF00D;
    mem[32'h304] = 32'h00A00093;

    step(); step();
    rst_n  = 1'b1;
    cmp_en = 1;
    check("rst_mem_req",  bus.mem_req,  1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_dm_ack",   bus.dm_ack,   1'b0);
    step();

    // Single zero-wait lw.
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h40;
    step();
    check("lw_c1_mem_req",  bus.mem_req,   1'b1);
    check("lw_c1_addr",     bus.mem_addr,  32'h40);
    check("lw_c1_stall",    bus.stall_mem, 1'b1);
    step();
    check("lw_c2_dm_ack",   bus.dm_ack,    1'b1);
    check("lw_c2_rdata",    bus.dm_rdata,  32'hDEADBEEF);
    check("lw_c2_mem_req",  bus.mem_req,   1'b0);
    bus.dm_req = 0;
    step(); step();

    // Simultaneous fetch and sw, 2-cycle memory: data first, fetch granted from the ack cycle.
    mem_wait = 1;
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h80; bus.dm_wdata = 32'h12345678;
    step();
    check("sim_c1_we",    bus.mem_we,    1'b1);
    check("sim_c1_addr",  bus.mem_addr,  32'h80);
    check("sim_c1_wdata", bus.mem_wdata, 32'h12345678);
    step();
    step();
    check("sim_c3_dm_ack", bus.dm_ack, 1'b1);
    bus.dm_req = 0;
    step();
    check("sim_c4_addr", bus.mem_addr, 32'h100);
    check("sim_c4_we",   bus.mem_we,   1'b0);
    step();
    step();
    check("sim_c6_if_ack", bus.if_ack,   1'b1);
    check("sim_c6_rdata",  bus.if_rdata, 32'h00000093);
    bus.if_req = 0;
    step(); step();

    // Starvation: fetch is flushed in every dm_ack cycle so only the counter can let it in.
    mem_wait = 0;
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h20;
    exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    prev_req = bus.mem_req;
    for (int c = 0; c < 80 && grants.size() < 10; c++) begin
      step();
      bus.if_flush = bus.dm_ack;
      if (bus.mem_req === 1'b1 && prev_req !== 1'b1)
        grants.push_back((bus.mem_we == 1'b0 && bus.mem_addr == 32'h200) ? 1 : 2);
      prev_req = bus.mem_req;
      if (grants.size() == 10) bus.dm_req = 0;
    end
    bus.if_flush = 0;
    check("starve_grant_count", grants.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < grants.size()) check($sformatf("starve_grant_%0d", i), grants[i], exp_seq[i]);
    end
    wait_if_ack("starve_if_ack");
    bus.if_req = 0;
    step(); step();

    // Flush mid-fetch with 3-cycle memory: response dropped, redirected fetch waits for mem_ack.
    mem_wait = 2;
    bus.if_req = 1; bus.if_addr = 32'h300;
    step();
    check("fl_c1_addr", bus.mem_addr, 32'h300);
    bus.if_flush = 1; bus.if_addr = 32'h304;
    step();
    bus.if_flush = 0;
    check("fl_c2_if_ack", bus.if_ack, 1'b0);
    step();
    check("fl_c3_if_ack", bus.if_ack, 1'b0);
    step();
    check("fl_c4_if_ack",  bus.if_ack,   1'b0);
    check("fl_c4_rdata",   bus.if_rdata, 32'h00000013);
    check("fl_c4_mem_req", bus.mem_req,  1'b0);
    step();
    check("fl_c5_mem_req", bus.mem_req,  1'b1);
    check("fl_c5_addr",    bus.mem_addr, 32'h304);
    wait_if_ack("fl_refetch_ack");
    check("fl_refetch_rdata", bus.if_rdata, 32'h00A00093);
    bus.if_req = 0;
    step();

    // Reset during a data access, then a stray memory response in IDLE.
    mem_wait = 3;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h40;
    step();
    check("rb_c1_mem_req", bus.mem_req, 1'b1);
    step();
    rst_n = 0; bus.dm_req = 0;
    step();
    check("rb_c3_mem_req",  bus.mem_req,  1'b0);
    check("rb_c3_mem_addr", bus.mem_addr, 32'h0);
    check("rb_c3_if_rdata", bus.if_rdata, 32'h0);
    rst_n = 1;
    force_ack = 1; force_data = 32'hBAD0BAD0;
    step();
    step();
    check("rb_c5_dm_ack",   bus.dm_ack,   1'b0);
    check("rb_c5_dm_rdata", bus.dm_rdata, 32'h0);
    check("rb_c5_mem_req",  bus.mem_req,  1'b0);
    step();

    // Store then load of the same word.
    mem_wait = 0;
    dm_access(1'b1, 32'h10, 32'hA5A5A5A5, rd);
    check("wr_rdata_held", rd, 32'h0);
    step();
    dm_access(1'b0, 32'h10, 32'h0, rd);
    check("rd_rdata", rd, 32'hA5A5A5A5);
    step(); step();

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port memory between the pipeline's instruction-fetch (IF) requester and data-memory (MEM-stage lw/sw) requester.
- Sequences each access as a req/ack transaction and returns read data to the granted requester.
- Generates stall signals for the hazard/stall logic.
- Data accesses have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_WIDTH, 32, byte address width of requesters and memory port
- DATA_WIDTH, 32, data word width (matches REG_DATA_WIDTH)
- STARVE_LIM, 4, consecutive data grants with fetch pending before fetch is forced to win (range 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- if_req  in  1  fetch request; held until if_ack or flush
- if_addr  in  ADDR_WIDTH  fetch address (PC)
- if_flush  in  1  branch/jal redirect; cancels the current fetch
- if_rdata  out  DATA_WIDTH  fetched instruction, valid when if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; held stable until dm_ack
- dm_we  in  1  1 = sw (write), 0 = lw (read)
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_rdata  out  DATA_WIDTH  load data, valid when dm_ack=1
- dm_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory transaction active
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, may arrive in the first mem_req cycle
- stall_if  out  1  combinational: if_req & ~if_ack
- stall_mem  out  1  combinational: dm_req & ~dm_ack

Behaviour:
- Reset values: state IDLE; mem_req, mem_we, if_ack, dm_ack = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starvation counter = 0.
- FSM states: IDLE, BUSY_IF, BUSY_DM, BUSY_DROP.
- IDLE grant rules:
  - eligible IF = if_req & ~if_flush & ~if_ack
  - eligible DM = dm_req & ~dm_ack (a requester's req is ignored in the cycle its own ack is high)
  - Both eligible: DM wins unless counter == STARVE_LIM, in which case IF wins.
  - Grant to DM: next state BUSY_DM; mem_req<=1, mem_we<=dm_we, mem_addr<=dm_addr, mem_wdata<=dm_wdata.
  - Grant to IF: next state BUSY_IF; mem_req<=1, mem_we<=0, mem_addr<=if_addr.
- Starvation counter:
  - Increments (saturating at STARVE_LIM) on each DM grant while if_req=1.
  - Clears on IF grant, or when if_req=0 in IDLE.
- BUSY_x: mem_* are held stable until mem_ack=1. At that edge:
  - mem_req<=0, mem_we<=0, state<=IDLE
  - x_ack<=1 for exactly one cycle
  - if_rdata<=mem_rdata for IF; dm_rdata<=mem_rdata for DM reads only
  - dm_rdata holds its previous value on writes
- Flush:
  - if_flush=1 in BUSY_IF moves the FSM to BUSY_DROP. The memory transaction still completes, but if_ack stays 0 and if_rdata is not updated.
  - BUSY_DROP returns to IDLE on mem_ack.
  - if_flush in IDLE blocks the IF grant for that cycle only.
- Latency:
  - Request at cycle 0 with zero-wait memory: mem_req=1 in cycle 1, x_ack=1 in cycle 2.
  - Back-to-back grants to the other requester are possible in the ack cycle.
  - The same requester is re-granted no earlier than the cycle after its ack.
- mem_ack while in IDLE is ignored.
- Reset mid-transaction returns all state to reset values; any outstanding memory response is ignored.
- Requester signals changing while BUSY do not affect the latched mem_* values.

Test Plan:
- Single lw: dm_req=1, dm_we=0, dm_addr=0x40; memory acks in first cycle with 0xDEADBEEF -> mem_req high in cycle 1 only; dm_ack=1 with dm_rdata=0xDEADBEEF in cycle 2; stall_mem high for cycles 0-1.
- Simultaneous requests: if_req with if_addr=0x100, and dm_req sw of 0x12345678 to 0x80, 2-cycle memory -> DM served first (mem_we=1, mem_addr=0x80); IF granted in the dm_ack cycle; if_ack follows 3 cycles later.
- Starvation: STARVE_LIM=4, if_req and dm_req held continuously -> exactly 4 DM grants, then 1 IF grant, then counter returns to 0.
- Flush mid-fetch: BUSY_IF with 3-cycle memory, if_flush pulsed in cycle 1 -> no if_ack; if_rdata unchanged; new fetch granted no earlier than the cycle after mem_ack.
- Reset in BUSY_DM: rst_n=0 for 1 cycle -> all outputs 0 on the next edge; a late mem_ack is ignored; no dm_ack.
- Write then read: sw of 0xA5A5A5A5 to 0x10, then lw from 0x10 -> dm_rdata unchanged after the sw ack and equal to 0xA5A5A5A5 after the lw ack.
